// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and widths for the iterative shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_COUNT_W = 5;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Request/result bundle of the multiplier; master issues operands, slave computes.
interface shift_add_multiplier_if;
  import mult_pkg::*;

  logic                  start;
  logic [MULT_WIDTH-1:0] mcand;
  logic [MULT_WIDTH-1:0] mplier;
  logic                  busy;
  logic                  done;
  logic [MULT_WIDTH-1:0] product;
  logic                  overflow;

  modport master (
    output start, mcand, mplier,
    input  busy, done, product, overflow
  );

  modport slave (
    input  start, mcand, mplier,
    output busy, done, product, overflow
  );

endinterface

// File: rtl/shift_add_multiplier_lsh.sv
// LeftShifterWithDiscard: shifts a 32-bit value left by one, dropping the MSB.
module LeftShifterWithDiscard
  import mult_pkg::*;
(
  input  logic [MULT_WIDTH-1:0] ValueIn,
  output logic [MULT_WIDTH-1:0] ValueOut
);

  assign ValueOut = {ValueIn[MULT_WIDTH-2:0], 1'b0};

endmodule

// File: rtl/shift_add_multiplier.sv
// Iterative unsigned 32x32 multiplier keeping the low 32 product bits, with overflow flag.
// Optional macro SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN stops once no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for start, result held
// RUN   | one multiplier bit retired per cycle
// DONE  | one-cycle result pulse; start here restarts immediately
module shift_add_multiplier
  import mult_pkg::*;
(
  input logic                   clk_i,
  input logic                   rst_i,
  shift_add_multiplier_if.slave bus
);

  mult_state_t             state_q, state_d;
  logic [MULT_WIDTH-1:0]   mcand_q, mcand_d;
  logic [MULT_WIDTH-1:0]   mplier_q, mplier_d;
  logic [MULT_WIDTH-1:0]   acc_q, acc_d;
  logic [MULT_COUNT_W-1:0] count_q, count_d;
  logic                    lost_q, lost_d;
  logic                    ovf_q, ovf_d;

  logic [MULT_WIDTH-1:0]   mcand_shifted;
  logic [MULT_WIDTH:0]     sum;
  logic                    last_iter;

  LeftShifterWithDiscard u_lsh (
    .ValueIn  (mcand_q),
    .ValueOut (mcand_shifted)
  );

  assign sum = {1'b0, acc_q} + {1'b0, mcand_q};

`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
  assign last_iter = ((mplier_q >> 1) == '0) || (count_q == 5'd31);
`else
  assign last_iter = (count_q == 5'd31);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      lost_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      lost_q   <= lost_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    lost_d   = lost_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          mcand_d  = bus.mcand;
          mplier_d = bus.mplier;
          acc_d    = '0;
          count_d  = '0;
          lost_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // A lost multiplicand bit only matters if a later add would have used it
        if (mplier_q[0]) begin
          acc_d = sum[MULT_WIDTH-1:0];
          if (sum[MULT_WIDTH] || lost_q) ovf_d = 1'b1;
        end
        if (mcand_q[MULT_WIDTH-1]) lost_d = 1'b1;
        mcand_d  = mcand_shifted;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 5'd1;
        if (last_iter) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.product  = acc_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: random and directed operands vs. a 64-bit arithmetic model.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_add_multiplier_if bus();

  shift_add_multiplier dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] full;
    full  = {32'b0, a} * {32'b0, b};
    e.p   = full[31:0];
    e.ovf = (full[63:32] != 32'b0);
`ifdef SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN
    e.n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) e.n = i + 1;
`else
    e.n = 32;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is presented
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) chk("done_and_busy", {31'b0, bus.busy}, 32'd0);
    if (rst) begin
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1, expected no result at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("product", bus.product, e.p);
        chk("overflow", {31'b0, bus.overflow}, {31'b0, e.ovf});
        chk("busy_cycles", 32'(busy_cnt), 32'(e.n));
      end
      busy_cnt = 0;
    end else begin
      busy_cnt = 0;
    end
  end

  task automatic do_op(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: busy still 1 after %0d cycles, expected 0", t);
    end
    bus.start  = 1'b1;
    bus.mcand  = a;
    bus.mplier = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int t;
    logic [31:0] ra, rb;
    bus.start  = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_product", bus.product, 32'd0);
    chk("rst_overflow", {31'b0, bus.overflow}, 32'd0);
    repeat (5) @(negedge clk);

    do_op(32'd6, 32'd7);
    drain();
    do_op(32'h0001_0000, 32'h0001_0000);
    do_op(32'hFFFF_FFFF, 32'd1);
    do_op(32'hFFFF_FFFF, 32'd2);
    do_op(32'h0000_1234, 32'd0);
    drain();

    // Start while busy must be ignored; start in the Done cycle must be taken
    do_op(32'd3, 32'd5);
    bus.start  = 1'b1;
    bus.mcand  = 32'd9;
    bus.mplier = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    t = 0;
    while (!bus.done && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done_seen", {31'b0, bus.done}, 32'd1);
    bus.start  = 1'b1;
    bus.mcand  = 32'd9;
    bus.mplier = 32'd9;
    sb.push_back(model(32'd9, 32'd9));
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // Reset at edge 10 of a run aborts it without a result
    bus.start  = 1'b1;
    bus.mcand  = 32'h1234_5678;
    bus.mplier = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_product", bus.product, 32'd0);
    chk("abort_overflow", {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    do_op(32'd2, 32'd3);
    drain();

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 4 == 1) ra = ra >> $urandom_range(0, 31);
      do_op(ra, rb);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
# shift_add_multiplier

Iterative unsigned 32×32 multiplier that keeps only the low 32 bits of the product. It retires one multiplier bit per clock: it conditionally adds the multiplicand, then shifts the multiplicand left by one and drops the MSB. It is the sequential consumer of the team's LeftShifterWithDiscard stage, which performs the per-cycle multiplicand shift. It sits in the execute path and reports overflow when discarded product bits are non-zero.

## Interface
- Parameters: none. The datapath is fixed at 32 bits to match LeftShifterWithDiscard.
- Clock  in  1  rising-edge clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled only in IDLE or DONE.
- Multiplicand  in  32  unsigned operand A; captured when Start is accepted.
- Multiplier  in  32  unsigned operand B; captured when Start is accepted.
- Busy  out  1  high while in RUN.
- Done  out  1  single-cycle pulse; the result is valid from this cycle on.
- Product  out  32  low 32 bits of A×B; held until the next accepted Start.
- Overflow  out  1  high when the true product is ≥ 2^32; held with Product.

## Operation
- Internal registers:
  - McandReg[31:0] and MplierReg[31:0]: working operands.
  - Acc[31:0]: accumulator.
  - Count[4:0]: iteration counter.
  - Lost: sticky; set when a 1 has been shifted out of McandReg.
  - OvfReg: overflow accumulator.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, with Start=1: load McandReg=A, MplierReg=B. Clear Acc, Count, Lost and OvfReg. Go to RUN.
  - RUN, one iteration per cycle:
    - If MplierReg[0]=1: Acc ← Acc + McandReg, truncated to 32 bits.
    - If that add produces a carry-out, or Lost=1 while an add is performed, set OvfReg.
    - McandReg ← LeftShifterWithDiscard(McandReg).
    - If McandReg[31]=1 before the shift, set Lost.
    - MplierReg ← MplierReg >> 1. Count ← Count + 1.
  - RUN → DONE when the terminating condition holds (see Configuration).
  - DONE → IDLE after one cycle, unless Start=1 (back-to-back restart).
- Outputs:
  - Product = Acc and Overflow = OvfReg, in every state.
  - Busy = (state == RUN). Done = (state == DONE).
- Start while in RUN is ignored; operands are not re-sampled.
- Arithmetic is unsigned only, with no sign handling.

## Timing
- Reset values: Busy=0, Done=0, Product=0, Overflow=0, state=IDLE. All internal registers are 0.
- Reset has priority over everything. Reset asserted mid-RUN aborts the operation: outputs read the reset values in the cycle after the reset edge, and Done is not produced.
- Start accepted at edge 0: iterations occur at edges 1..N, and Done is high for exactly one cycle following edge N.
- Without the macro, N = 32 always.
- Busy is high after edges 0..N-1 and low when Done is high.
- Done and Busy are never high together.
- Throughput with back-to-back starts: one result per N+1 cycles.

## Configuration
- Macro: SHIFT_ADD_MULTIPLIER_EARLY_TERM_EN.
- Defined:
  - RUN → DONE when (MplierReg >> 1) == 0 or Count == 31, evaluated in the same cycle as the iteration.
  - N = max(index of highest set bit of B + 1, 1). For B=0, N=1.
  - Results are identical to the non-terminating build.
- Undefined: RUN → DONE only when Count == 31, so N = 32 for every operand.

## Structure
- Shared package mult_pkg holds:
  - typedef enum logic [1:0] mult_state_t {IDLE, RUN, DONE};
  - localparam MULT_WIDTH = 32;
  - localparam MULT_COUNT_W = 5.
- One sub-module: the existing LeftShifterWithDiscard, instantiated once. Its ValueIn is McandReg; its ValueOut is the next McandReg. No other sub-modules.
- Expected size: about 150 lines of RTL.

## Test plan
- Reset held for 2 cycles, then released -> Busy=0, Done=0, Product=0x00000000, Overflow=0; no Done appears without Start.
- A=6, B=7, Start pulsed -> Product=42 and Overflow=0.
  - Without the macro, Done is high only in the cycle after edge 32.
  - With the macro, Done is high only in the cycle after edge 3.
  - Busy is high for exactly N cycles.
- A=0x00010000, B=0x00010000 -> Product=0x00000000, Overflow=1.
- A=0xFFFFFFFF, B=1 -> Product=0xFFFFFFFF, Overflow=0.
- A=0xFFFFFFFF, B=2 -> Product=0xFFFFFFFE, Overflow=1.
- Start (A=3, B=5) is followed by Start (A=9, B=9) pulsed while Busy -> the second request is ignored and Product=15.
  - Start (A=9, B=9) asserted in the Done cycle -> accepted; the next Done gives Product=81.
- Reset asserted at edge 10 of a run with A=0x12345678, B=0xFFFFFFFF:
  - The next cycle reads Busy=0, Done=0, Product=0, Overflow=0, and no Done follows.
  - A fresh Start with A=2, B=3 then gives Product=6.
